// File: rtl/pc_ctrl.sv
// Next-PC sequencer with instruction-fetch request/grant handshake and redirect flush.
// Optional PC_CTRL_MISALIGN_EN: misaligned jump targets are replaced by TRAP_VEC and flagged.
module pc_ctrl #(
    parameter int unsigned                 CPU_WIDTH  = 32,
    parameter logic [CPU_WIDTH-1:0]        RESET_ADDR = 'h0,
    parameter logic [CPU_WIDTH-1:0]        TRAP_VEC   = 'h100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CPU_WIDTH-1:0] curr_pc_i,
    output logic [CPU_WIDTH-1:0] next_pc_o,
    output logic                 if_req_o,
    input  logic                 if_gnt_i,
    input  logic                 stall_i,
    input  logic                 jump_en_i,
    input  logic [CPU_WIDTH-1:0] jump_addr_i,
    input  logic                 trap_en_i,
    output logic                 flush_o,
    output logic                 misalign_o
);

    // state | meaning
    // BOOT  | first cycle after reset, PC loads RESET_ADDR, no fetch
    // RUN   | normal fetch, redirect or stall handled in one cycle
    // WAIT  | fetch outstanding, address held until grant
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [CPU_WIDTH-1:0]   pend_pc_q, pend_pc_d;

    logic                   redir;
    logic                   jump_bad;
    logic [CPU_WIDTH-1:0]   jump_tgt;
    logic [CPU_WIDTH-1:0]   redir_tgt;
    logic [CPU_WIDTH-1:0]   pc_inc;

    always_comb begin
        redir    = trap_en_i | jump_en_i;
        jump_tgt = jump_addr_i;
        jump_bad = 1'b0;
`ifdef PC_CTRL_MISALIGN_EN
        // only a jump that actually wins selection can be flagged
        if (jump_addr_i[1:0] != 2'b00) begin
            jump_tgt = TRAP_VEC;
            jump_bad = jump_en_i & ~trap_en_i;
        end
`endif
        redir_tgt = trap_en_i ? TRAP_VEC : jump_tgt;
        pc_inc    = curr_pc_i + CPU_WIDTH'(4);
    end

    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        next_pc_o  = curr_pc_i;
        if_req_o   = 1'b0;
        flush_o    = 1'b0;
        misalign_o = 1'b0;

        case (state_q)
            BOOT: begin
                next_pc_o = RESET_ADDR;
                state_d   = RUN;
            end
            RUN: begin
                if (redir) begin
                    next_pc_o  = redir_tgt;
                    flush_o    = 1'b1;
                    misalign_o = jump_bad;
                end else if (!stall_i) begin
                    if_req_o = 1'b1;
                    if (if_gnt_i) begin
                        next_pc_o = pc_inc;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if_req_o = 1'b1;
                if (if_gnt_i) begin
                    if (redir) begin
                        next_pc_o  = redir_tgt;
                        flush_o    = 1'b1;
                        misalign_o = jump_bad;
                    end else if (pend_vld_q) begin
                        next_pc_o = pend_pc_q;
                        flush_o   = 1'b1;
                    end else begin
                        next_pc_o = pc_inc;
                    end
                    pend_vld_d = 1'b0;
                    state_d    = RUN;
                end else if (redir) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = redir_tgt;
                    misalign_o = jump_bad;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // reset overrides everything so outputs are defined before the first edge
        if (!rst_n) begin
            state_d    = BOOT;
            pend_vld_d = 1'b0;
            pend_pc_d  = '0;
            next_pc_o  = RESET_ADDR;
            if_req_o   = 1'b0;
            flush_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC sequencer sitting in front of the program counter register. Each cycle it computes the address the PC register loads: sequential `+4`, branch/jump target, trap vector, or hold. It also runs the request/grant handshake with instruction memory, so a fetch address stays stable until it is accepted. It pulses a flush to the IF/ID stage whenever a redirect is applied.

## Interface
Parameters:
- `RESET_ADDR`, `'h0`: address driven on `next_pc_o` during reset and boot.
- `TRAP_VEC`, `'h100`: trap target address.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `curr_pc_i`, input, `CPU_WIDTH`: current PC from the PC register; this is also the fetch address.
- `next_pc_o`, output, `CPU_WIDTH`: value the PC register loads at the next edge.
- `if_req_o`, output, 1: fetch request to instruction memory.
- `if_gnt_i`, input, 1: fetch accepted this cycle; only meaningful while `if_req_o=1`.
- `stall_i`, input, 1: pipeline hazard stall.
- `jump_en_i`, input, 1: branch/jump redirect request.
- `jump_addr_i`, input, `CPU_WIDTH`: redirect target.
- `trap_en_i`, input, 1: trap redirect to `TRAP_VEC`.
- `flush_o`, output, 1: one-cycle pulse that kills the IF/ID instruction.
- `misalign_o`, output, 1: misaligned-target pulse; tied to 0 unless `PC_CTRL_MISALIGN_EN` is defined.

## Operation
- FSM states: BOOT, RUN, WAIT. Registers: `state`, `pend_vld`, `pend_pc`.
- Redirect selection, per cycle: `trap_en_i` → `TRAP_VEC`; else `jump_en_i` → `jump_addr_i`. Trap wins when both are high.
- BOOT:
  - `next_pc_o=RESET_ADDR`, `if_req_o=0`.
  - Next state is RUN unconditionally.
- RUN, redirect present:
  - `next_pc_o=target`, `flush_o=1`, `if_req_o=0`.
  - Stay in RUN.
  - Redirect overrides `stall_i`.
- RUN, no redirect, `stall_i=1`:
  - `if_req_o=0`, `next_pc_o=curr_pc_i`, stay in RUN.
- RUN, no redirect, no stall:
  - `if_req_o=1`.
  - If `if_gnt_i=1`: `next_pc_o=curr_pc_i+4`, stay in RUN.
  - Else: `next_pc_o=curr_pc_i`, go to WAIT.
- WAIT:
  - `if_req_o=1`, `next_pc_o=curr_pc_i`. Request and address stay stable until grant; `stall_i` is ignored.
  - A redirect arriving without grant is latched: `pend_vld=1`, `pend_pc=target`. A later redirect overwrites the earlier one (last wins).
- WAIT, `if_gnt_i=1`:
  - `next_pc_o` = same-cycle redirect target if one is present; else `pend_pc` if `pend_vld`; else `curr_pc_i+4`.
  - `flush_o=1` if a redirect or pending redirect is applied.
  - Clear `pend_vld` and go to RUN.
- Arithmetic: `+4` is modulo 2^`CPU_WIDTH`; `'hFFFF_FFFC` wraps to 0. No overflow flag.

## Timing
- Reset values (while `rst_n=0` at the edge):
  - `state=BOOT`, `pend_vld=0`, `pend_pc=0`.
  - Outputs during reset: `next_pc_o=RESET_ADDR`, `if_req_o=0`, `flush_o=0`, `misalign_o=0`.
- Outputs are combinational from `state`, `pend_*` and inputs; zero-cycle latency to the PC register.
- The first request is raised one cycle after `rst_n` rises (the BOOT cycle).
- Redirect latency:
  - 1 cycle in RUN: the target appears on `curr_pc_i` the next cycle.
  - In WAIT: the grant cycle plus 1.
- `flush_o` is high for exactly the cycle in which the redirect target is driven onto `next_pc_o`, never longer.
- Reset asserted mid-WAIT: the pending redirect is discarded, `if_req_o` drops at that edge, and the block returns to BOOT.

## Configuration
- `PC_CTRL_MISALIGN_EN` defined:
  - A jump target with `jump_addr_i[1:0]!=0` is replaced by `TRAP_VEC`.
  - `misalign_o` pulses 1 cycle, in the cycle the substituted target is applied, or is latched into `pend_pc`.
  - Trap targets are never checked.
- `PC_CTRL_MISALIGN_EN` undefined: jump targets pass unchanged and `misalign_o` is constant 0.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles.
  - During reset: `next_pc_o=0`, `if_req_o=0`, `flush_o=0`.
  - After release: 1 BOOT cycle with `if_req_o=0`, then `if_req_o=1` with `curr_pc_i=0`.
- Streaming with `if_gnt_i=1` and no stall: `curr_pc_i` sequence is 0, 4, 8, `'hC`, `'h10`; `flush_o` stays 0.
- Grant held low 3 cycles at PC 8:
  - `if_req_o=1` and `next_pc_o=8` for 3 cycles.
  - On grant: `next_pc_o='hC`, state returns to RUN.
- Jump to `'h40` in WAIT at PC 8, grant 2 cycles later:
  - PC holds 8 through the wait.
  - Grant cycle: `next_pc_o='h40`, `flush_o=1` for one cycle.
  - Next cycle: `curr_pc_i='h40`.
- Trap plus jump (`'h80`) in the same RUN cycle: `next_pc_o='h100`. Separately, a granted fetch at `'hFFFF_FFFC` gives `next_pc_o=0`.
- Jump to `'h42`:
  - With the macro: `next_pc_o='h100`, `misalign_o` 1-cycle pulse, `flush_o=1`.
  - Without the macro: `next_pc_o='h42`, `misalign_o=0`.
